river_crossing_ctrl: RTL and testbench

Sequential game controller for the farmer/cabbage/goat/wolf river-crossing puzzle. It holds the bank position of all four actors, accepts one move per handshake, and validates each move against the danger rule. It tracks a move count and ends the game as WON or LOST. It sits between the switch/button front end and the LED/seven-segment display logic, and supersedes the stand-alone combinational danger detector.

---
 rtl/river_pkg.sv | 36 +++
 rtl/river_crossing_ctrl_if.sv | 31 +++
 rtl/river_unsafe.sv | 15 +
 rtl/river_crossing_ctrl.sv | 98 +++++++++
 tb/tb_river_crossing_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/river_pkg.sv
`default_nettype none
// ============================================================================
// Module   : river_pkg
// Brief    : Shared types and constants for the river-crossing game controller
// Revision : 1.0 - initial release
// ============================================================================
package river_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WON  = 2'd2,
        ST_LOST = 2'd3
    } game_state_e;

    localparam logic [1:0] SEL_FARMER  = 2'd0;
    localparam logic [1:0] SEL_CABBAGE = 2'd1;
    localparam logic [1:0] SEL_GOAT    = 2'd2;
    localparam logic [1:0] SEL_WOLF    = 2'd3;

    localparam int F = 3;
    localparam int C = 2;
    localparam int G = 1;
    localparam int W = 0;

    localparam logic [3:0] WIN_BANK    = 4'b1111;
    localparam logic [3:0] FARMER_MASK = 4'b1000;

    // Something gets eaten when a predator/prey pair shares a bank without the farmer
    function automatic logic is_unsafe(input logic [3:0] b);
        return ((b[G] == b[W]) && (b[F] != b[G])) ||
               ((b[C] == b[G]) && (b[F] != b[C]));
    endfunction

endpackage
`default_nettype wire

// File: rtl/river_crossing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : river_crossing_ctrl_if
// Brief    : Move handshake and game status bundle for the river-crossing game
// Revision : 1.0 - initial release
// ============================================================================
interface river_crossing_ctrl_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             mv_valid;
    logic [1:0]       mv_sel;
    logic             mv_ready;
    logic             mv_ack;
    logic             mv_err;
    logic [3:0]       bank;
    logic             unsafe;
    logic [CNT_W-1:0] moves;
    logic [1:0]       game_state;

    modport master (
        output start, mv_valid, mv_sel,
        input  mv_ready, mv_ack, mv_err, bank, unsafe, moves, game_state
    );

    modport slave (
        input  start, mv_valid, mv_sel,
        output mv_ready, mv_ack, mv_err, bank, unsafe, moves, game_state
    );
endinterface
`default_nettype wire

// File: rtl/river_unsafe.sv
`default_nettype none
// ============================================================================
// Module   : river_unsafe
// Brief    : Combinational danger check on a {f,c,g,w} bank vector
// Revision : 1.0 - initial release
// ============================================================================
module river_unsafe
    import river_pkg::*;
(
    input  logic [3:0] bank_i,
    output logic       unsafe_o
);
    assign unsafe_o = is_unsafe(bank_i);
endmodule
`default_nettype wire

// File: rtl/river_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : river_crossing_ctrl
// Brief    : River-crossing game FSM: move validation, move counter, win/loss
// Revision : 1.0 - initial release
// ============================================================================
module river_crossing_ctrl
    import river_pkg::*;
#(
    parameter int CNT_W          = 5,
    parameter int MAX_MOVES      = 20,
    parameter int LOSE_ON_UNSAFE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    river_crossing_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_MOVES);

    game_state_e      state_q;
    logic [3:0]       bank_q;
    logic [3:0]       bank_d;
    logic [3:0]       item_mask;
    logic [CNT_W-1:0] moves_q;
    logic [CNT_W-1:0] moves_d;
    logic             ack_q;
    logic             err_q;
    logic             xfer;
    logic             item_ok;
    logic             cur_unsafe;
    logic             next_unsafe;
    logic             reject;

    river_unsafe u_unsafe_cur  (.bank_i(bank_q), .unsafe_o(cur_unsafe));
    river_unsafe u_unsafe_next (.bank_i(bank_d), .unsafe_o(next_unsafe));

    assign bus.mv_ready = (state_q == ST_PLAY) && !bus.start;
    assign xfer         = bus.mv_valid && bus.mv_ready;

    always_comb begin
        item_mask = 4'b0000;
        case (bus.mv_sel)
            SEL_CABBAGE: item_mask[C] = 1'b1;
            SEL_GOAT:    item_mask[G] = 1'b1;
            SEL_WOLF:    item_mask[W] = 1'b1;
            default:     item_mask = 4'b0000;
        endcase
    end

    // The selected item must sit on the same bank as the farmer
    assign item_ok = ((bank_q ^ {4{bank_q[F]}}) & item_mask) == 4'b0000;
    assign bank_d  = bank_q ^ (item_mask | FARMER_MASK);
    assign moves_d = (moves_q == {CNT_W{1'b1}}) ? moves_q : moves_q + CNT_W'(1);
    assign reject  = !item_ok || (next_unsafe && (LOSE_ON_UNSAFE == 0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bank_q  <= 4'b0000;
            moves_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            if (bus.start) begin
                state_q <= ST_PLAY;
                bank_q  <= 4'b0000;
                moves_q <= '0;
            end else if (xfer) begin
                ack_q <= 1'b1;
                if (reject) begin
                    err_q <= 1'b1;
                end else begin
                    bank_q  <= bank_d;
                    moves_q <= moves_d;
                    // Unsafe loss first, then win, then running out of moves
                    if (next_unsafe) begin
                        state_q <= ST_LOST;
                    end else if (bank_d == WIN_BANK) begin
                        state_q <= ST_WON;
                    end else if (moves_d >= C_MAX_CNT) begin
                        state_q <= ST_LOST;
                    end
                end
            end
        end
    end

    assign bus.bank       = bank_q;
    assign bus.moves      = moves_q;
    assign bus.game_state = state_q;
    assign bus.unsafe     = cur_unsafe;
    assign bus.mv_ack     = ack_q;
    assign bus.mv_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_river_crossing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_river_crossing_ctrl
// Brief    : Scoreboard bench for river_crossing_ctrl with three configurations
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_river_crossing_ctrl;
    import river_pkg::*;

    typedef struct packed {
        logic       err;
        logic [3:0] bank;
        logic [4:0] moves;
        logic [1:0] st;
    } exp_t;

    typedef struct packed {
        logic       ack;
        logic       err;
        logic [3:0] bank;
        logic [4:0] moves;
        logic [1:0] st;
        logic       unsafe;
        logic       ready;
    } obs_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      st_s  = 3'b000;
    logic [2:0]      vld_s = 3'b000;
    logic [2:0][1:0] sel_s = '0;
    exp_t            q [3][$];
    int              checks = 0;
    int              errors = 0;

    always #5 clk = ~clk;

    river_crossing_ctrl_if #(.CNT_W(5)) ifa ();
    river_crossing_ctrl_if #(.CNT_W(5)) ifb ();
    river_crossing_ctrl_if #(.CNT_W(5)) ifc ();

    assign ifa.start = st_s[0];  assign ifa.mv_valid = vld_s[0];  assign ifa.mv_sel = sel_s[0];
    assign ifb.start = st_s[1];  assign ifb.mv_valid = vld_s[1];  assign ifb.mv_sel = sel_s[1];
    assign ifc.start = st_s[2];  assign ifc.mv_valid = vld_s[2];  assign ifc.mv_sel = sel_s[2];

    river_crossing_ctrl #(.CNT_W(5), .MAX_MOVES(20), .LOSE_ON_UNSAFE(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    river_crossing_ctrl #(.CNT_W(5), .MAX_MOVES(20), .LOSE_ON_UNSAFE(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    river_crossing_ctrl #(.CNT_W(5), .MAX_MOVES(3), .LOSE_ON_UNSAFE(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    function automatic exp_t mk(input logic e, input logic [3:0] b,
                                input logic [4:0] m, input logic [1:0] s);
        return {e, b, m, s};
    endfunction

    function automatic obs_t mko(input logic a, input logic e, input logic [3:0] b,
                                 input logic [4:0] m, input logic [1:0] s,
                                 input logic u, input logic r);
        return {a, e, b, m, s, u, r};
    endfunction

    function automatic obs_t get_obs(input int d);
        case (d)
            0:       return {ifa.mv_ack, ifa.mv_err, ifa.bank, ifa.moves, ifa.game_state, ifa.unsafe, ifa.mv_ready};
            1:       return {ifb.mv_ack, ifb.mv_err, ifb.bank, ifb.moves, ifb.game_state, ifb.unsafe, ifb.mv_ready};
            default: return {ifc.mv_ack, ifc.mv_err, ifc.bank, ifc.moves, ifc.game_state, ifc.unsafe, ifc.mv_ready};
        endcase
    endfunction

    // Monitor: every ack pops one scoreboard entry for that instance
    task automatic mon(input int d, input exp_t got);
        exp_t e;
        checks++;
        if (q[d].size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected dut%0d got err=%0b bank=%b moves=%0d state=%0d required no ack",
                     d, got.err, got.bank, got.moves, got.st);
        end else begin
            e = q[d].pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL ack_resp dut%0d got err=%0b bank=%b moves=%0d state=%0d required err=%0b bank=%b moves=%0d state=%0d",
                         d, got.err, got.bank, got.moves, got.st, e.err, e.bank, e.moves, e.st);
            end
        end
    endtask

    always @(negedge clk) begin
        if (ifa.mv_ack === 1'b1) mon(0, {ifa.mv_err, ifa.bank, ifa.moves, ifa.game_state});
        if (ifb.mv_ack === 1'b1) mon(1, {ifb.mv_err, ifb.bank, ifb.moves, ifb.game_state});
        if (ifc.mv_ack === 1'b1) mon(2, {ifc.mv_err, ifc.bank, ifc.moves, ifc.game_state});
    end

    task automatic chk_obs(input string name, input int d, input obs_t e);
        obs_t g;
        g = get_obs(d);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s dut%0d got ack=%0b err=%0b bank=%b moves=%0d state=%0d unsafe=%0b ready=%0b required ack=%0b err=%0b bank=%b moves=%0d state=%0d unsafe=%0b ready=%0b",
                     name, d, g.ack, g.err, g.bank, g.moves, g.st, g.unsafe, g.ready,
                     e.ack, e.err, e.bank, e.moves, e.st, e.unsafe, e.ready);
        end
    endtask

    task automatic chk_drained(input string name, input int d);
        checks++;
        if (q[d].size() != 0) begin
            errors++;
            $display("FAIL %s dut%0d got %0d outstanding acks required 0", name, d, q[d].size());
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start(input int d);
        st_s[d] = 1'b1;
        cyc();
        st_s[d] = 1'b0;
    endtask

    task automatic move(input int d, input logic [1:0] s, input exp_t e);
        vld_s[d] = 1'b1;
        sel_s[d] = s;
        q[d].push_back(e);
        cyc();
        vld_s[d] = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        for (int d = 0; d < 3; d++)
            chk_obs("reset_state", d, mko(1'b0, 1'b0, 4'b0000, 5'd0, ST_IDLE, 1'b0, 1'b0));

        // Optimal solution, valid held across all seven moves
        do_start(0);
        move(0, 2'd2, mk(1'b0, 4'b1010, 5'd1, ST_PLAY));
        move(0, 2'd0, mk(1'b0, 4'b0010, 5'd2, ST_PLAY));
        move(0, 2'd1, mk(1'b0, 4'b1110, 5'd3, ST_PLAY));
        move(0, 2'd2, mk(1'b0, 4'b0100, 5'd4, ST_PLAY));
        move(0, 2'd3, mk(1'b0, 4'b1101, 5'd5, ST_PLAY));
        move(0, 2'd0, mk(1'b0, 4'b0101, 5'd6, ST_PLAY));
        move(0, 2'd2, mk(1'b0, 4'b1111, 5'd7, ST_WON));
        settle();
        chk_obs("optimal_won", 0, mko(1'b1, 1'b0, 4'b1111, 5'd7, ST_WON, 1'b0, 1'b0));
        chk_drained("optimal_acks", 0);

        // Wolf requested while it is on the other bank from the farmer
        do_start(0);
        move(0, 2'd2, mk(1'b0, 4'b1010, 5'd1, ST_PLAY));
        move(0, 2'd3, mk(1'b1, 4'b1010, 5'd1, ST_PLAY));
        settle();
        chk_obs("wrong_bank", 0, mko(1'b1, 1'b1, 4'b1010, 5'd1, ST_PLAY, 1'b0, 1'b1));
        chk_drained("wrong_bank_acks", 0);

        // Start together with a valid move restarts without a transfer
        do_start(0);
        move(0, 2'd2, mk(1'b0, 4'b1010, 5'd1, ST_PLAY));
        move(0, 2'd0, mk(1'b0, 4'b0010, 5'd2, ST_PLAY));
        st_s[0]  = 1'b1;
        vld_s[0] = 1'b1;
        sel_s[0] = 2'd2;
        cyc();
        st_s[0]  = 1'b0;
        vld_s[0] = 1'b0;
        settle();
        chk_obs("start_with_valid", 0, mko(1'b0, 1'b0, 4'b0000, 5'd0, ST_PLAY, 1'b0, 1'b1));
        chk_drained("start_with_valid_acks", 0);

        // Unsafe first move loses the game
        do_start(0);
        move(0, 2'd1, mk(1'b0, 4'b1100, 5'd1, ST_LOST));
        settle();
        chk_obs("unsafe_lost", 0, mko(1'b1, 1'b0, 4'b1100, 5'd1, ST_LOST, 1'b1, 1'b0));
        chk_drained("unsafe_lost_acks", 0);

        // Same move rejected when unsafe moves do not lose
        do_start(1);
        move(1, 2'd1, mk(1'b1, 4'b0000, 5'd0, ST_PLAY));
        settle();
        chk_obs("unsafe_reject", 1, mko(1'b1, 1'b1, 4'b0000, 5'd0, ST_PLAY, 1'b0, 1'b1));
        chk_drained("unsafe_reject_acks", 1);

        // Move limit of three, then a fourth request must not be taken
        do_start(2);
        move(2, 2'd2, mk(1'b0, 4'b1010, 5'd1, ST_PLAY));
        move(2, 2'd2, mk(1'b0, 4'b0000, 5'd2, ST_PLAY));
        move(2, 2'd2, mk(1'b0, 4'b1010, 5'd3, ST_LOST));
        vld_s[2] = 1'b1;
        sel_s[2] = 2'd2;
        cyc();
        vld_s[2] = 1'b0;
        settle();
        chk_obs("max_moves_lost", 2, mko(1'b0, 1'b0, 4'b1010, 5'd3, ST_LOST, 1'b0, 1'b0));
        chk_drained("max_moves_acks", 2);

        // Asynchronous reset in the middle of a cycle with a move pending
        do_start(0);
        move(0, 2'd2, mk(1'b0, 4'b1010, 5'd1, ST_PLAY));
        settle();
        vld_s[0] = 1'b1;
        sel_s[0] = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        chk_obs("async_reset", 0, mko(1'b0, 1'b0, 4'b0000, 5'd0, ST_IDLE, 1'b0, 1'b0));
        chk_obs("async_reset_c", 2, mko(1'b0, 1'b0, 4'b0000, 5'd0, ST_IDLE, 1'b0, 1'b0));
        cyc();
        vld_s[0] = 1'b0;
        rst_n    = 1'b1;
        cyc();
        settle();
        chk_obs("after_reset", 0, mko(1'b0, 1'b0, 4'b0000, 5'd0, ST_IDLE, 1'b0, 1'b0));
        for (int d = 0; d < 3; d++)
            chk_drained("final_acks", d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
